// File: rtl/axi4_chan_buffer_if.sv
// axi4_chan_buffer_if: upstream/downstream handshake bundle for one buffered AXI4 channel
interface axi4_chan_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] infoIn;
    logic                  infoInValid;
    logic                  readyForInfo;
    logic [DATA_WIDTH-1:0] infoOut;
    logic                  infoOutValid;
    logic                  readyForOut;
    modport master (output infoIn, infoInValid, readyForOut, input readyForInfo, infoOut, infoOutValid);
    modport slave (input infoIn, infoInValid, readyForOut, output readyForInfo, infoOut, infoOutValid);
endinterface

// File: rtl/axi4_chan_buffer.sv
// axi4_chan_buffer: single-clock AXI4 channel buffer (passthrough, forward reg, skid slice or FIFO)
module axi4_chan_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int MODE       = 2,
    parameter int DEPTH      = 4,
    parameter int AF_LEVEL   = 3,
    localparam int LW        = $clog2(DEPTH + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic                  flush,
    axi4_chan_buffer_if.slave     bus,
    output logic [LW-1:0]         level,
    output logic                  almostFull
);
    generate
        if (MODE == 0) begin : g_pass
            assign bus.infoOut      = bus.infoIn;
            assign bus.infoOutValid = bus.infoInValid;
            assign bus.readyForInfo = bus.readyForOut;
            assign level            = '0;
            assign almostFull       = 1'b0;
        end else if (MODE == 1) begin : g_fwd
            logic                  v;
            logic                  en;
            logic                  push;
            logic [DATA_WIDTH-1:0] d;
            // en keeps ready low until the first edge after reset release
            assign bus.readyForInfo = en & (~v | bus.readyForOut);
            assign push             = bus.infoInValid & bus.readyForInfo;
            always_ff @(posedge ACLK) begin
                if (!ARESETN) begin
                    v  <= 1'b0;
                    d  <= '0;
                    en <= 1'b0;
                end else begin
                    en <= 1'b1;
                    if (flush)
                        v <= 1'b0;
                    else if (push) begin
                        v <= 1'b1;
                        d <= bus.infoIn;
                    end else if (bus.readyForOut)
                        v <= 1'b0;
                end
            end
            assign bus.infoOut      = d;
            assign bus.infoOutValid = v;
            assign level            = LW'(v);
            assign almostFull       = 1'b0;
        end else if (MODE == 2) begin : g_slice
            logic                  m_v;
            logic                  s_v;
            logic                  rdy;
            logic                  push;
            logic                  m_load;
            logic [DATA_WIDTH-1:0] m_d;
            logic [DATA_WIDTH-1:0] s_d;
            assign push   = bus.infoInValid & rdy;
            assign m_load = ~m_v | bus.readyForOut;
            always_ff @(posedge ACLK) begin
                if (!ARESETN) begin
                    m_v <= 1'b0;
                    s_v <= 1'b0;
                    rdy <= 1'b0;
                    m_d <= '0;
                    s_d <= '0;
                end else if (flush) begin
                    m_v <= 1'b0;
                    s_v <= 1'b0;
                    rdy <= 1'b1;
                end else if (m_load) begin
                    m_v <= s_v | push;
                    if (s_v | push)
                        m_d <= s_v ? s_d : bus.infoIn;
                    s_v <= 1'b0;
                    rdy <= 1'b1;
                end else if (push) begin
                    s_v <= 1'b1;
                    s_d <= bus.infoIn;
                    rdy <= 1'b0;
                end
            end
            assign bus.infoOut      = m_d;
            assign bus.infoOutValid = m_v;
            assign bus.readyForInfo = rdy;
            assign level            = LW'(m_v) + LW'(s_v);
            assign almostFull       = 1'b0;
        end else begin : g_fifo
            localparam int PW = $clog2(DEPTH);
            logic [DATA_WIDTH-1:0] mem [DEPTH];
            logic [DATA_WIDTH-1:0] o_d;
            logic [PW-1:0]         wr;
            logic [PW-1:0]         rd;
            logic [LW-1:0]         lvl;
            logic [LW-1:0]         lvl_n;
            logic [LW-1:0]         mcnt;
            logic                  o_v;
            logic                  rdy;
            logic                  af;
            logic                  push;
            logic                  pop;
            logic                  o_load;
            logic                  take;
            logic                  bypass;
            function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
                return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
            endfunction
            // mcnt is the count held in storage, excluding the output register
            assign push   = bus.infoInValid & rdy;
            assign pop    = o_v & bus.readyForOut;
            assign o_load = ~o_v | pop;
            assign mcnt   = lvl - LW'(o_v);
            assign take   = o_load & (mcnt != '0);
            assign bypass = o_load & (mcnt == '0) & push;
            assign lvl_n  = lvl + LW'(push) - LW'(pop);
            always_ff @(posedge ACLK) begin
                if (!ARESETN) begin
                    o_v <= 1'b0;
                    o_d <= '0;
                    rdy <= 1'b0;
                    af  <= 1'b0;
                    lvl <= '0;
                    wr  <= '0;
                    rd  <= '0;
                end else if (flush) begin
                    o_v <= 1'b0;
                    rdy <= 1'b1;
                    af  <= 1'b0;
                    lvl <= '0;
                    wr  <= '0;
                    rd  <= '0;
                end else begin
                    lvl <= lvl_n;
                    rdy <= lvl_n < LW'(DEPTH);
                    af  <= lvl_n >= LW'(AF_LEVEL);
                    if (o_load) begin
                        o_v <= take | push;
                        if (take)
                            o_d <= mem[rd];
                        else if (push)
                            o_d <= bus.infoIn;
                    end
                    if (take)
                        rd <= nxt(rd);
                    if (push & ~bypass)
                        wr <= nxt(wr);
                end
            end
            always_ff @(posedge ACLK)
                if (ARESETN & ~flush & push & ~bypass)
                    mem[wr] <= bus.infoIn;
            assign bus.infoOut      = o_d;
            assign bus.infoOutValid = o_v;
            assign bus.readyForInfo = rdy;
            assign level            = lvl;
            assign almostFull       = af;
        end
    endgenerate
endmodule

// File: doc/axi4_chan_buffer.md
Name: axi4_chan_buffer

Overview:
- Single-clock, parametrised buffer for one AXI4 channel. The channel payload is a packed vector carrying the handshake pair.
- Successor to the per-channel CDC buffering on the slave side of the interconnect, for use when master/slave and crossbar share a clock.
- Instantiated once per channel (AW, W, AR, R, B). Each instance selects one mode: passthrough, forward register, full register slice, or FIFO of DEPTH entries.
- Adds occupancy reporting, an almost-full flag and a synchronous flush.

Parameters:
- DATA_WIDTH, 32: packed channel payload width (1..1024).
- MODE, 2: 0 = passthrough, 1 = forward register, 2 = full register slice (2-entry skid), 3 = FIFO.
- DEPTH, 4: FIFO entries when MODE=3 (2..256; need not be a power of two). Ignored otherwise.
- AF_LEVEL, 3: almostFull asserts when level >= AF_LEVEL (1..DEPTH, MODE=3 only).
- LW, $clog2(DEPTH+1): level port width (localparam, derived).

Ports:
- ACLK  in  1  clock; all state updates on the rising edge.
- ARESETN  in  1  reset, active-low, synchronous.
- flush  in  1  synchronous clear of all buffered beats.
- infoIn  in  DATA_WIDTH  upstream payload.
- infoInValid  in  1  upstream valid.
- readyForInfo  out  1  upstream ready.
- infoOut  out  DATA_WIDTH  downstream payload.
- infoOutValid  out  1  downstream valid.
- readyForOut  in  1  downstream ready.
- level  out  LW  number of beats currently held.
- almostFull  out  1  level >= AF_LEVEL.

Behaviour:
- Transfer rules: a push is infoInValid & readyForInfo at the edge. A pop is infoOutValid & readyForOut at the edge.
- Valid handshake: infoOutValid, once high, stays high with infoOut stable until popped. Flush and reset are the only exceptions.
- Reset, ARESETN low at an edge, MODE 1-3:
  - infoOutValid=0, infoOut=0, level=0, almostFull=0.
  - readyForInfo=0 while ARESETN is low. It rises on the first edge after release.
  - Reset mid-burst discards all held beats. No partial beat is presented afterwards.
- MODE 0:
  - Pure wires: infoOut=infoIn, infoOutValid=infoInValid, readyForInfo=readyForOut.
  - level=0, almostFull=0. Reset and flush have no effect.
- MODE 1 (forward register):
  - infoOut and infoOutValid are registered. readyForInfo = ~infoOutValid | readyForOut (combinational).
  - Latency 1 cycle. Sustains 1 beat/cycle. level is 0 or 1.
- MODE 2 (full slice):
  - Main register plus skid register. Both readyForInfo and infoOutValid are driven from flops. No combinational ready or valid path crosses the block.
  - readyForInfo = skid empty.
  - If downstream stalls while a push occurs, the beat goes to skid. When skid is non-empty, the next pop refills main from skid.
  - Latency 1 cycle. 1 beat/cycle with readyForOut held high. level is 0..2.
- MODE 3 (FIFO):
  - Circular storage with rd/wr pointers that wrap from DEPTH-1 to 0. Explicit compare, so non-power-of-two DEPTH is supported.
  - Output is registered. First-word latency is 1 cycle: a push into an empty FIFO gives infoOutValid=1 on the next edge.
  - readyForInfo = (level < DEPTH), registered. It does not depend on readyForOut, so a full FIFO refuses a push even in a pop cycle.
  - Simultaneous push and pop with 0 < level < DEPTH: level unchanged, order preserved.
  - level counts every held beat, including the one in the output register.
  - almostFull is registered and updates on the same edge as level.
- Flush, MODE 1-3:
  - At an edge with flush=1: all beats dropped, level=0, infoOutValid=0 on the next cycle.
  - A push in the same cycle is discarded.
  - readyForInfo stays per the normal rule, evaluated as empty after the flush edge.
  - The caller must only flush when protocol-safe (the block does not check this).
- Width rules:
  - level saturates by construction; it never exceeds DEPTH (MODE 3), 2 (MODE 2) or 1 (MODE 1).
  - Pointer and level arithmetic use LW and $clog2(DEPTH) bits with no overflow.

Test Plan:
- MODE 3, DEPTH=4, AF_LEVEL=3, readyForOut=0: push 0x11, 0x22, 0x33, 0x44 → level 1,2,3,4; almostFull high from level 3; readyForInfo=0 at level 4; a 5th beat 0x55 held on infoIn is not accepted.
- MODE 3, DEPTH=3 (non-power-of-two): 10 beats 0..9 streamed with readyForOut toggling 1010… → output order exactly 0..9, no loss or duplication, pointer wrap exercised three times.
- MODE 2, readyForOut=1: beats A,B,C,D on consecutive cycles → infoOut A,B,C,D on cycles 1-4. Deassert readyForOut one cycle mid-stream → B held stable, next beat in skid, level=2, readyForInfo=0, then drains with no bubble.
- MODE 1: push 0xDEAD while downstream stalled → infoOutValid=1, infoOut=0xDEAD next cycle; readyForInfo=0 until pop; pop and new push in the same cycle both accepted.
- Reset and flush with MODE 3 holding 3 beats: flush=1 for one edge together with push 0x99 → level=0, infoOutValid=0, 0x99 never appears. Repeat with ARESETN=0 → all outputs 0, readyForInfo=0 during reset, 1 on the first edge after release.
- MODE 0: random valid/ready/data → outputs equal inputs in the same cycle; level=0 and almostFull=0 throughout, including during reset.
